cell_scan_mux: RTL and testbench
================================

// Module: cell_scan_mux
// PURPOSE
//  Parametrised successor to the board-cell selector. Picks one of NCELLS packed
//  WIDTH-bit cells from the board bus. It has two modes:
//   - direct: registered random access by index.
//   - scan: snapshots the board and streams every cell out in order, with
//     valid/ready backpressure.
//  Sits between board storage and the display/win-check logic.
// PARAMETERS
//  WIDTH   16  bits per cell
//  NCELLS  9   number of board cells (3x3 default)
//  SEL_W   4   index width; must satisfy 2**SEL_W >= NCELLS
// PORTS
//  clk        in   1             system clock, rising edge
//  rst_n      in   1             asynchronous active-low reset
//  mode       in   1             0 = direct, 1 = scan (sampled only in IDLE)
//  sel        in   SEL_W         direct-mode cell index
//  in_bus     in   NCELLS*WIDTH  packed cells; cell k = in_bus[k*WIDTH +: WIDTH]
//  start      in   1             scan request pulse
//  abort      in   1             synchronous scan cancel
//  out_ready  in   1             downstream ready (scan mode only)
//  out_data   out  WIDTH         selected cell value
//  out_idx    out  SEL_W         index of out_data
//  out_valid  out  1             out_data/out_idx valid
//  busy       out  1             high in SCAN and DONE
//  done       out  1             one-cycle pulse after the last cell is accepted
//  sel_err    out  1             one-cycle pulse: direct sel >= NCELLS
// BEHAVIOUR
//  Reset: every register and output is 0; state = IDLE; snapshot = 0.
//  FSM states: IDLE, SCAN, DONE.
//  IDLE, mode=0 (direct):
//   - Each clk: out_data <= cell[sel], out_idx <= sel, out_valid <= 1.
//   - Latency is 1 cycle. out_ready is ignored.
//   - sel >= NCELLS: out_data and out_idx hold, out_valid <= 0, sel_err <= 1
//     for that cycle. Never latch and never X.
//  IDLE, mode=1, start=1:
//   - snap <= in_bus, idx <= 0, out_valid <= 0 -> SCAN.
//   - start with mode=0 is ignored.
//  SCAN:
//   - out_valid = 1, out_data = snap[idx], out_idx = idx.
//   - out_valid & out_ready: idx == NCELLS-1 -> DONE, else idx <= idx + 1.
//   - out_valid & !out_ready: data and idx held stable, no change.
//   - in_bus changes during SCAN do not affect output (snapshot only).
//   - start, mode and sel are ignored while busy.
//  DONE:
//   - done = 1 for exactly one cycle, out_valid = 0 -> IDLE.
//   - Next direct update occurs on the following cycle.
//  abort=1 in SCAN or DONE:
//   - -> IDLE next edge; out_valid <= 0; done not asserted.
//   - abort wins over a simultaneous final handshake.
//   - abort in IDLE has no effect.
//  Throughput: with out_ready held high a full scan is NCELLS transfer cycles,
//   plus 1 start cycle and 1 DONE cycle.
//  rst_n asserted mid-scan: immediate return to reset values; no done pulse.
//  idx never exceeds NCELLS-1; no wrap-around past the last cell.
// STRUCTURE
//  - Shared include board_defs.vh: CELL_W=16, NUM_CELLS=9, IDX_W=4, and
//    state encodings ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2.
//  - Sub-module cell_pick: combinational NCELLS:1 selector with an in-range
//    flag. Two instances: one for direct (in_bus, sel), one for scan
//    (snap, idx).
//  - The top level holds the FSM, the snapshot register and the output
//    registers.
// TESTING
//  1 direct: cells k = 16'h0A00+k, sel=0..8 -> out_data = 16'h0A00+sel one
//    cycle later, out_valid=1.
//  2 direct sel=4'd12 -> sel_err pulses 1 cycle, out_valid=0, out_data keeps
//    its last value.
//  3 scan with out_ready=1 -> 9 beats, out_idx 0..8, data matches cells
//    captured at start, done pulse; in_bus rewritten mid-scan does not change
//    the beats.
//  4 scan, out_ready low on beats 2 and 5 for 3 cycles each -> data/idx held
//    stable, no beat lost or duplicated, done after beat 8.
//  5 abort at beat 8 coincident with ready -> back to IDLE, done never
//    asserted; start while busy ignored.
//  6 rst_n low at beat 4 -> all outputs 0 asynchronously; after release a
//    fresh scan completes normally.

Source files
------------

// File: rtl/cell_scan_mux_pkg.sv
// Shared board geometry and the scan FSM state encoding for cell_scan_mux.
package cell_scan_mux_pkg;
    localparam int CELL_W    = 16;
    localparam int NUM_CELLS = 9;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/cell_scan_mux_pick.sv
// Combinational NCELLS:1 cell selector; out-of-range indices yield zero data
// and a cleared in_range flag, so no X can escape.
module cell_pick #(
    parameter int WIDTH  = 16,
    parameter int NCELLS = 9,
    parameter int SEL_W  = 4
) (
    input  logic [NCELLS*WIDTH-1:0] bus,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    in_range
);
    always_comb begin
        data     = '0;
        in_range = 1'b0;
        for (int k = 0; k < NCELLS; k++) begin
            if (sel == SEL_W'(k)) begin
                data     = bus[k*WIDTH +: WIDTH];
                in_range = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cell_scan_mux.sv
// Board cell selector: registered direct random access, or a snapshot scan
// that streams every cell out with valid/ready backpressure.
module cell_scan_mux
    import cell_scan_mux_pkg::*;
#(
    parameter int WIDTH  = CELL_W,
    parameter int NCELLS = NUM_CELLS,
    parameter int SEL_W  = IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NCELLS*WIDTH-1:0] in_bus,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    sel_err
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NCELLS - 1);

    state_t                    state;
    logic [NCELLS*WIDTH-1:0]   snap;
    logic [SEL_W-1:0]          idx;
    logic [WIDTH-1:0]          q_data;
    logic [SEL_W-1:0]          q_idx;
    logic                      q_valid;
    logic [WIDTH-1:0]          dir_data, scan_data;
    logic                      dir_ok, scan_ok;
    logic                      scanning;

    cell_pick #(.WIDTH(WIDTH), .NCELLS(NCELLS), .SEL_W(SEL_W)) u_dir (
        .bus(in_bus), .sel(sel), .data(dir_data), .in_range(dir_ok)
    );

    cell_pick #(.WIDTH(WIDTH), .NCELLS(NCELLS), .SEL_W(SEL_W)) u_scan (
        .bus(snap), .sel(idx), .data(scan_data), .in_range(scan_ok)
    );

    // Scan beats come straight off the snapshot so the first beat is valid
    // the cycle after start, giving NCELLS+2 cycles per full scan.
    assign scanning  = (state == ST_SCAN);
    assign out_valid = scanning ? scan_ok   : q_valid;
    assign out_data  = scanning ? scan_data : q_data;
    assign out_idx   = scanning ? idx       : q_idx;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            snap    <= '0;
            idx     <= '0;
            q_data  <= '0;
            q_idx   <= '0;
            q_valid <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!mode) begin
                        if (dir_ok) begin
                            q_data  <= dir_data;
                            q_idx   <= sel;
                            q_valid <= 1'b1;
                        end else begin
                            q_valid <= 1'b0;
                            sel_err <= 1'b1;
                        end
                    end else begin
                        q_valid <= 1'b0;
                        if (start) begin
                            snap  <= in_bus;
                            idx   <= '0;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    q_valid <= 1'b0;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (scan_ok && out_ready) begin
                        if (idx == LAST) state <= ST_DONE;
                        else             idx   <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    q_valid <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_scan_mux.sv
// Directed bench for cell_scan_mux: direct access, sel error, scan with
// backpressure, abort and mid-scan reset.
module tb_cell_scan_mux;
    localparam int W = 16;
    localparam int N = 9;
    localparam int S = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode;
    logic [S-1:0]     sel;
    logic [N*W-1:0]   in_bus;
    logic             start;
    logic             abort;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [S-1:0]     out_idx;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             sel_err;

    int checks = 0;
    int errors = 0;

    cell_scan_mux #(.WIDTH(W), .NCELLS(N), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_bus(in_bus),
        .start(start), .abort(abort), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .busy(busy), .done(done), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cells(input logic [W-1:0] base);
        for (int k = 0; k < N; k++) in_bus[k*W +: W] = base + W'(k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_bus = '0;
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        tick();
        checks++;
        if ({out_data, out_idx, out_valid, busy, done, sel_err} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %h/%h v%b b%b d%b e%b exp all 0",
                     out_data, out_idx, out_valid, busy, done, sel_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_direct();
        set_cells(16'h0A00);
        mode = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = S'(s);
            tick();
            checks++;
            if ({out_valid, sel_err, out_idx, out_data} !== {2'b10, S'(s), 16'h0A00 + W'(s)}) begin
                errors++;
                $display("FAIL direct sel=%0d got v%b e%b idx %0d data %h exp v1 e0 idx %0d data %h",
                         s, out_valid, sel_err, out_idx, out_data, s, 16'h0A00 + W'(s));
            end
        end
    endtask

    task automatic test_sel_err();
        sel = 4'd12;
        tick();
        checks++;
        if ({sel_err, out_valid, out_idx, out_data} !== {2'b10, 4'd8, 16'h0A08}) begin
            errors++;
            $display("FAIL sel_err got e%b v%b idx %0d data %h exp e1 v0 idx 8 data 0a08",
                     sel_err, out_valid, out_idx, out_data);
        end
        sel = 4'd3;
        tick();
        checks++;
        if ({sel_err, out_valid, out_idx, out_data} !== {2'b01, 4'd3, 16'h0A03}) begin
            errors++;
            $display("FAIL sel_err_clear got e%b v%b idx %0d data %h exp e0 v1 idx 3 data 0a03",
                     sel_err, out_valid, out_idx, out_data);
        end
    endtask

    task automatic test_scan();
        set_cells(16'h0B00);
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < N; b++) begin
            checks++;
            if ({busy, out_valid, done, out_idx, out_data} !== {3'b110, S'(b), 16'h0B00 + W'(b)}) begin
                errors++;
                $display("FAIL scan beat %0d got b%b v%b d%b idx %0d data %h exp b1 v1 d0 idx %0d data %h",
                         b, busy, out_valid, done, out_idx, out_data, b, 16'h0B00 + W'(b));
            end
            if (b == 3) set_cells(16'hFF00);
            tick();
        end
        checks++;
        if ({busy, out_valid, done} !== 3'b101) begin
            errors++;
            $display("FAIL scan_done got b%b v%b d%b exp b1 v0 d1", busy, out_valid, done);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL scan_idle got b%b d%b exp b0 d0", busy, done);
        end
        mode = 1'b0;
    endtask

    task automatic test_backpressure();
        set_cells(16'h0C00);
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < N; b++) begin
            if (b == 2 || b == 5) begin
                out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    checks++;
                    if ({out_valid, done, out_idx, out_data} !== {2'b10, S'(b), 16'h0C00 + W'(b)}) begin
                        errors++;
                        $display("FAIL bp_hold beat %0d got v%b d%b idx %0d data %h exp v1 d0 idx %0d data %h",
                                 b, out_valid, done, out_idx, out_data, b, 16'h0C00 + W'(b));
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, S'(b), 16'h0C00 + W'(b)}) begin
                errors++;
                $display("FAIL bp_beat %0d got v%b idx %0d data %h exp v1 idx %0d data %h",
                         b, out_valid, out_idx, out_data, b, 16'h0C00 + W'(b));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done got %b exp 1", done);
        end
        tick();
        mode = 1'b0;
    endtask

    task automatic test_abort();
        set_cells(16'h0D00);
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < N - 1; b++) begin
            if (b == 3) begin
                start = 1'b1; mode = 1'b0; sel = 4'd2;
            end
            if (b == 4) start = 1'b0;
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, S'(b), 16'h0D00 + W'(b)}) begin
                errors++;
                $display("FAIL abort_beat %0d got v%b idx %0d data %h exp v1 idx %0d data %h",
                         b, out_valid, out_idx, out_data, b, 16'h0D00 + W'(b));
            end
            tick();
        end
        abort = 1'b1;
        #1;
        checks++;
        if ({out_idx, done} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL abort_last got idx %0d d%b exp idx 8 d0", out_idx, done);
        end
        tick();
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle got b%b v%b d%b exp 000", busy, out_valid, done);
        end
        sel = 4'd5;
        tick();
        checks++;
        if ({busy, done, out_valid, out_idx, out_data} !== {3'b001, 4'd5, 16'h0D05}) begin
            errors++;
            $display("FAIL abort_in_idle got b%b d%b v%b idx %0d data %h exp b0 d0 v1 idx 5 data 0d05",
                     busy, done, out_valid, out_idx, out_data);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        set_cells(16'h0E00);
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 4; b++) tick();
        checks++;
        if (out_idx !== 4'd4) begin
            errors++;
            $display("FAIL rst_pre idx got %0d exp 4", out_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_data, out_idx, out_valid, busy, done, sel_err} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs got %h/%h v%b b%b d%b e%b exp all 0",
                     out_data, out_idx, out_valid, busy, done, sel_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < N; b++) begin
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, S'(b), 16'h0E00 + W'(b)}) begin
                errors++;
                $display("FAIL rescan beat %0d got v%b idx %0d data %h exp v1 idx %0d data %h",
                         b, out_valid, out_idx, out_data, b, 16'h0E00 + W'(b));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rescan_done got %b exp 1", done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_direct();
        test_sel_err();
        test_scan();
        test_backpressure();
        test_abort();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
